td4_exec_unit: RTL and testbench
================================

// Module: td4_exec_unit
// PURPOSE
//  Decode/execute stage of the TD4 4-bit CPU; sits directly upstream of register_4bit.
//  Consumes the ROM instruction byte plus register_4bit's OUT_A, OUT_B and ADDRESS.
//  Drives register_4bit's LOAD (active-low) and IN_DATA.
//  Owns the carry flag, halt detection, input-port synchroniser and retired-instruction counter.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop stages on IN_PORT (>=1)
//  CNT_W        16  width of retired-instruction counter (saturating)
// PORTS
//  CLK        in   1      single system clock; all state on rising edge
//  RST        in   1      synchronous, active-high reset
//  INSTR      in   8      ROM word at ADDRESS: [7:4] opcode, [3:0] immediate Im
//  REG_A      in   4      register_4bit OUT_A
//  REG_B      in   4      register_4bit OUT_B
//  PC         in   4      register_4bit ADDRESS
//  IN_PORT    in   4      external asynchronous input switches
//  LOAD       out  4      active-low load enables: [0]=A [1]=B [2]=OUT [3]=PC
//  IN_DATA    out  4      write data to register_4bit
//  CARRY      out  1      carry flag register
//  HALT       out  1      high once a jump-to-self has been executed
//  RETIRED    out  CNT_W  count of executed instructions (saturates at all-ones)
// BEHAVIOUR
//  - Reset (RST=1 at edge): CARRY=0, HALT=0, RETIRED=0, sync chain=0.
//    LOAD=4'b1111 and IN_DATA=4'h0 while RST high.
//  - LOAD/IN_DATA: combinational from INSTR, REG_*, PC, synced input, CARRY.
//    register_4bit captures them on the same edge (0-cycle latency).
//    Inactive LOAD[3] => register_4bit increments PC.
//  - Datapath: sum[4:0] = SEL + Im (5-bit). IN_DATA = sum[3:0]. cout = sum[4].
//  - Opcode table (SEL, LOAD):
//      0000 ADD A,Im  A,1110    0101 ADD B,Im  B,1101
//      0011 MOV A,Im  0,1110    0111 MOV B,Im  0,1101
//      0001 MOV A,B   B,1110    0100 MOV B,A   A,1101
//      0010 IN A      IN,1110   0110 IN B      IN,1101
//      1001 OUT B     B,1011    1011 OUT Im    0,1011
//      1111 JMP Im    0,0111    1110 JNC Im    0,(CARRY?1111:0111)
//      others: NOP, SEL=0, LOAD=1111, cout forced 0.
//  - CARRY <= cout on every non-halted, non-reset edge (all opcodes; JNC tests the old value).
//  - FSM {RUN, HALTED}:
//      RUN->HALTED when the current op actually loads PC with Im==PC (JMP, or JNC with CARRY=0).
//      HALTED: LOAD=4'b0111, IN_DATA=PC, CARRY frozen, RETIRED frozen, HALT=1.
//      Exit HALTED only via RST.
//  - RETIRED increments by 1 per RUN edge, including the halting instruction and NOPs.
//    Holds at {CNT_W{1'b1}}; no wrap.
//  - IN_PORT passes through SYNC_STAGES flops; IN A/B uses the last stage.
//  - Boundaries:
//      ADD overflow wraps IN_DATA mod 16 and sets CARRY.
//      Jump to PC=F wraps normally via register_4bit.
//      RST mid-HALT returns to RUN on the next edge.
//      RST asserted the same cycle as a halting JMP: reset wins.
// STRUCTURE
//  - Package td4_pkg: opcode localparams (OP_ADD_A..OP_JNC), SEL encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO),
//    LOAD constants (LD_A=4'b1110, LD_B=4'b1101, LD_OUT=4'b1011, LD_PC=4'b0111, LD_NONE=4'b1111),
//    FSM state encodings.
//  - One sub-module: td4_decoder (combinational opcode+CARRY -> SEL, LOAD, is_jump).
//    Mux, adder, flag, FSM and counter live in the top.
// TESTING
//  1. Reset: RST=1 two cycles -> LOAD=1111, CARRY=0, HALT=0, RETIRED=0.
//  2. REG_A=9, INSTR=0000_1001 -> IN_DATA=2, LOAD=1110; CARRY=1 after edge.
//  3. CARRY=1, INSTR=1110_0011 -> LOAD=1111 (no jump); CARRY=0 after edge.
//     Repeat the same INSTR -> LOAD=0111, IN_DATA=3.
//  4. IN_PORT=4'hC held 3 cycles, INSTR=0110_0001 -> IN_DATA=D, LOAD=1101.
//     Check the IN_PORT change appears only after SYNC_STAGES edges.
//  5. PC=5, INSTR=1111_0101 -> HALT=1 next edge, LOAD stays 0111, IN_DATA=5, RETIRED frozen.
//     RST -> HALT=0.
//  6. INSTR=1000_xxxx (undefined) -> LOAD=1111, CARRY=0, RETIRED+1.
//     Run 2^CNT_W+3 cycles with CNT_W=4 -> RETIRED=F.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared opcode, operand-select, load-enable and FSM encodings for the TD4 exec stage.
package td4_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    // Active-low register_4bit load enables: [0]=A [1]=B [2]=OUT [3]=PC
    localparam logic [3:0] LD_A    = 4'b1110;
    localparam logic [3:0] LD_B    = 4'b1101;
    localparam logic [3:0] LD_OUT  = 4'b1011;
    localparam logic [3:0] LD_PC   = 4'b0111;
    localparam logic [3:0] LD_NONE = 4'b1111;

    typedef enum logic [1:0] {SEL_A, SEL_B, SEL_IN, SEL_ZERO} sel_e;

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

endpackage

// File: rtl/td4_decoder.sv
// Opcode decode: picks the adder operand, the load enable, and flags PC-loading ops.
import td4_pkg::*;

module td4_decoder (
    input  logic [3:0] i_op,
    input  logic       i_carry,
    output sel_e       o_sel,
    output logic [3:0] o_load,
    output logic       o_is_jump,
    output logic       o_cout_en
);

    always_comb begin
        o_sel     = SEL_ZERO;
        o_load    = LD_NONE;
        o_is_jump = 1'b0;
        o_cout_en = 1'b1;
        case (i_op)
            OP_ADD_A:  begin o_sel = SEL_A;    o_load = LD_A;   end
            OP_MOV_AB: begin o_sel = SEL_B;    o_load = LD_A;   end
            OP_IN_A:   begin o_sel = SEL_IN;   o_load = LD_A;   end
            OP_MOV_A:  begin o_sel = SEL_ZERO; o_load = LD_A;   end
            OP_MOV_BA: begin o_sel = SEL_A;    o_load = LD_B;   end
            OP_ADD_B:  begin o_sel = SEL_B;    o_load = LD_B;   end
            OP_IN_B:   begin o_sel = SEL_IN;   o_load = LD_B;   end
            OP_MOV_B:  begin o_sel = SEL_ZERO; o_load = LD_B;   end
            OP_OUT_B:  begin o_sel = SEL_B;    o_load = LD_OUT; end
            OP_OUT_IM: begin o_sel = SEL_ZERO; o_load = LD_OUT; end
            OP_JMP:    begin o_load = LD_PC; o_is_jump = 1'b1; end
            // JNC only branches while carry is clear
            OP_JNC: begin
                o_load    = i_carry ? LD_NONE : LD_PC;
                o_is_jump = ~i_carry;
            end
            default:   o_cout_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/td4_exec_unit.sv
// TD4 decode/execute stage: operand mux, 4-bit adder, carry flag, halt FSM,
// input-port synchroniser and saturating retired-instruction counter.
import td4_pkg::*;

module td4_exec_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       INSTR,
    input  logic [3:0]       REG_A,
    input  logic [3:0]       REG_B,
    input  logic [3:0]       PC,
    input  logic [3:0]       IN_PORT,
    output logic [3:0]       LOAD,
    output logic [3:0]       IN_DATA,
    output logic             CARRY,
    output logic             HALT,
    output logic [CNT_W-1:0] RETIRED
);

    logic [3:0]       r_sync [SYNC_STAGES];
    logic             r_carry;
    logic [CNT_W-1:0] r_retired;
    state_e           r_state, w_state_next;

    sel_e       w_sel;
    logic [3:0] w_dec_load;
    logic       w_is_jump;
    logic       w_cout_en;
    logic [3:0] w_im;
    logic [3:0] w_operand;
    logic [4:0] w_sum;
    logic       w_cout;

    assign w_im = INSTR[3:0];

    td4_decoder u_dec (
        .i_op      (INSTR[7:4]),
        .i_carry   (r_carry),
        .o_sel     (w_sel),
        .o_load    (w_dec_load),
        .o_is_jump (w_is_jump),
        .o_cout_en (w_cout_en)
    );

    always_comb begin
        w_operand = 4'h0;
        case (w_sel)
            SEL_A:   w_operand = REG_A;
            SEL_B:   w_operand = REG_B;
            SEL_IN:  w_operand = r_sync[SYNC_STAGES-1];
            default: w_operand = 4'h0;
        endcase
    end

    assign w_sum  = {1'b0, w_operand} + {1'b0, w_im};
    assign w_cout = w_sum[4] & w_cout_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'h0;
        end else begin
            r_sync[0] <= IN_PORT;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    // Halt on a jump that actually lands on its own address
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_RUN && w_is_jump && w_im == PC)
            w_state_next = ST_HALTED;
    end

    always_comb begin
        LOAD    = w_dec_load;
        IN_DATA = w_sum[3:0];
        if (RST) begin
            LOAD    = LD_NONE;
            IN_DATA = 4'h0;
        end else if (r_state == ST_HALTED) begin
            LOAD    = LD_PC;
            IN_DATA = PC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_carry   <= 1'b0;
            r_retired <= '0;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_cout;
            if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign CARRY   = r_carry;
    assign HALT    = (r_state == ST_HALTED);
    assign RETIRED = r_retired;

endmodule

// File: tb/tb_td4_exec_unit.sv
// Directed bench for td4_exec_unit, built with a 4-bit counter to reach saturation quickly.
module tb_td4_exec_unit;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [7:0]       INSTR;
    logic [3:0]       REG_A, REG_B, PC, IN_PORT;
    logic [3:0]       LOAD, IN_DATA;
    logic             CARRY, HALT;
    logic [CNT_W-1:0] RETIRED;

    int checks   = 0;
    int failures = 0;

    td4_exec_unit #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .REG_A(REG_A), .REG_B(REG_B),
        .PC(PC), .IN_PORT(IN_PORT), .LOAD(LOAD), .IN_DATA(IN_DATA),
        .CARRY(CARRY), .HALT(HALT), .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; INSTR = 8'h00; REG_A = 4'h0; REG_B = 4'h0; PC = 4'h0; IN_PORT = 4'h0;
        step(); step();
        chk("rst_load",    16'(LOAD),    16'hF);
        chk("rst_indata",  16'(IN_DATA), 16'h0);
        chk("rst_carry",   16'(CARRY),   16'h0);
        chk("rst_halt",    16'(HALT),    16'h0);
        chk("rst_retired", 16'(RETIRED), 16'h0);

        // ADD A,9 with A=9 overflows
        RST = 1'b0; REG_A = 4'h9; INSTR = 8'h09; #1;
        chk("add_indata", 16'(IN_DATA), 16'h2);
        chk("add_load",   16'(LOAD),    16'hE);
        step();
        chk("add_carry",   16'(CARRY),   16'h1);
        chk("add_retired", 16'(RETIRED), 16'h1);

        // JNC 3 with carry set: not taken, carry clears
        PC = 4'h1; INSTR = 8'hE3; #1;
        chk("jnc_c1_load", 16'(LOAD), 16'hF);
        step();
        chk("jnc_c1_carry", 16'(CARRY), 16'h0);
        PC = 4'h2; #1;
        chk("jnc_c0_load",   16'(LOAD),    16'h7);
        chk("jnc_c0_indata", 16'(IN_DATA), 16'h3);
        step();
        chk("jnc_nohalt",    16'(HALT),    16'h0);
        chk("jnc_retired",   16'(RETIRED), 16'h3);

        // IN B,1 through the two-stage synchroniser
        IN_PORT = 4'hC; INSTR = 8'h61; #1;
        chk("in_sync0", 16'(IN_DATA), 16'h1);
        step();
        chk("in_sync1", 16'(IN_DATA), 16'h1);
        step();
        chk("in_sync2_data", 16'(IN_DATA), 16'hD);
        chk("in_sync2_load", 16'(LOAD),    16'hD);
        step();
        chk("in_retired", 16'(RETIRED), 16'h6);

        // JMP 5 at PC=5 halts
        PC = 4'h5; INSTR = 8'hF5; #1;
        chk("jmp_load",   16'(LOAD),    16'h7);
        chk("jmp_indata", 16'(IN_DATA), 16'h5);
        step();
        chk("halt_set",     16'(HALT),    16'h1);
        chk("halt_retired", 16'(RETIRED), 16'h7);
        REG_A = 4'h9; INSTR = 8'h09; #1;
        chk("halt_load",   16'(LOAD),    16'h7);
        chk("halt_indata", 16'(IN_DATA), 16'h5);
        step();
        chk("halt_carry_frozen", 16'(CARRY),   16'h0);
        chk("halt_ret_frozen",   16'(RETIRED), 16'h7);
        chk("halt_held",         16'(HALT),    16'h1);

        RST = 1'b1; step();
        chk("halt_rst_halt",    16'(HALT),    16'h0);
        chk("halt_rst_retired", 16'(RETIRED), 16'h0);

        // Reset wins over a halting JMP in the same cycle
        PC = 4'h5; INSTR = 8'hF5; #1;
        chk("rstjmp_load", 16'(LOAD), 16'hF);
        step();
        chk("rstjmp_halt", 16'(HALT), 16'h0);
        RST = 1'b0;

        // Undefined opcode clears carry and still retires
        REG_A = 4'h9; INSTR = 8'h09; step();
        chk("pre_nop_carry", 16'(CARRY), 16'h1);
        INSTR = 8'h85; #1;
        chk("nop_load", 16'(LOAD), 16'hF);
        step();
        chk("nop_carry",   16'(CARRY),   16'h0);
        chk("nop_retired", 16'(RETIRED), 16'h2);

        for (int i = 0; i < 19; i++) step();
        chk("sat_retired", 16'(RETIRED), 16'hF);
        step();
        chk("sat_hold", 16'(RETIRED), 16'hF);

        // Remaining datapath routes
        REG_A = 4'h7; INSTR = 8'h40; #1;
        chk("movba_data", 16'(IN_DATA), 16'h7);
        chk("movba_load", 16'(LOAD),    16'hD);
        INSTR = 8'hB6; #1;
        chk("outim_data", 16'(IN_DATA), 16'h6);
        chk("outim_load", 16'(LOAD),    16'hB);
        REG_B = 4'hA; INSTR = 8'h13; #1;
        chk("movab_data", 16'(IN_DATA), 16'hD);
        chk("movab_load", 16'(LOAD),    16'hE);
        REG_B = 4'hF; INSTR = 8'h51; #1;
        chk("addb_data", 16'(IN_DATA), 16'h0);
        chk("addb_load", 16'(LOAD),    16'hD);
        step();
        chk("addb_carry", 16'(CARRY), 16'h1);

        // Jump to F from a different PC does not halt
        PC = 4'h3; INSTR = 8'hFF; #1;
        chk("jmpf_data", 16'(IN_DATA), 16'hF);
        step();
        chk("jmpf_nohalt", 16'(HALT),  16'h0);
        chk("jmpf_carry",  16'(CARRY), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
